// File: rtl/fifo_pkg.sv
// Shared widths and status bundle for the single-clock FIFO.
// Consumers may pack the FIFO flags into fifo_status_t.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, count, thresholds, sticky flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      r_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_cfg
      $error("sync_fifo_ctrl: illegal DEPTH or threshold levels");
    end
  endgenerate

  logic [PW-1:0]         w_ptr_q, w_ptr_d;
  logic [PW-1:0]         r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status_t          st;

  always_comb begin
    st              = '0;
    st.empty        = (w_ptr_q == r_ptr_q);
    st.full         = (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]) &&
                      (w_ptr_q[AW] != r_ptr_q[AW]);
    st.almost_full  = (count_q >= AF_L);
    st.almost_empty = (count_q <= AE_L);
    st.overflow     = ovf_q;
    st.underflow    = unf_q;
  end

  assign wr_acc = w_en && !st.full;
  assign rd_acc = r_en && !st.empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (wr_acc) w_ptr_d = w_ptr_q + PW'(1);
    if (rd_acc) r_ptr_d = r_ptr_q + PW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (w_en && st.full);
    unf_d = unf_q || (r_en && st.empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (w_ptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (r_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem_rdata;
  assign rd_valid = !st.empty;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    dout_d     = rd_acc ? mem_rdata : dout_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl in registered-output mode, DEPTH=8, DATA_WIDTH=8.
// Outputs are compared each cycle against a queue-based reference.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] q [$];
  logic       m_ovf;
  logic       m_unf;
  logic       m_valid;
  logic [7:0] m_dout;

  function automatic logic [18:0] obs();
    return {data_out, rd_valid, count, full, empty,
            almost_full, almost_empty, overflow, underflow};
  endfunction

  function automatic logic [18:0] expv();
    int n;
    n = q.size();
    return {m_dout, m_valid, 4'(n), n == 8, n == 0,
            n >= 6, n <= 2, m_ovf, m_unf};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    @(posedge clk);
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit full_m, empty_m;
    @(negedge clk);
    w_en = w; data_in = d; r_en = r;
    full_m  = (q.size() == 8);
    empty_m = (q.size() == 0);
    @(posedge clk);
    m_valid = r && !empty_m;
    if (m_valid) m_dout = q.pop_front();
    if (w && !full_m) q.push_back(d);
    m_ovf = m_ovf | (w && full_m);
    m_unf = m_unf | (r && empty_m);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs(), expv());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_idle: got %h expected %h", obs(), expv());
      end
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, (i <= 8) ? 8'(i) : 8'hFF, 1'b0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 26; i++) begin
      if (i < 5)       cycle(1'b1, 8'($urandom), 1'b0);
      else if (i < 10) cycle(1'b0, 8'h00, 1'b1);
      else if (i < 18) cycle(1'b1, 8'hA0 + 8'(i - 10), 1'b0);
      else             cycle(1'b0, 8'h00, 1'b1);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 4)       cycle(1'b1, 8'($urandom), 1'b0);
      else if (i < 14) cycle(1'b1, 8'($urandom), 1'b1);
      else if (i < 18) cycle(1'b1, 8'($urandom), 1'b0);
      else             cycle(1'b1, 8'($urandom), 1'b1);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL simul[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    do_reset();
    n_run++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", obs(), expv());
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      cycle(1'b1, 8'h5A, 1'b0);
      else if (i == 1) cycle(1'b0, 8'h00, 1'b1);
      else             cycle(1'b0, 8'h00, 1'b1);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic w, r;
      int bias;
      bias = (i / 100) % 2;
      w = ($urandom_range(0, 9) < (bias ? 7 : 4));
      r = ($urandom_range(0, 9) < (bias ? 4 : 7));
      cycle(w, 8'($urandom), r);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
